// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the streamline CPU.
// Write-back source encodings and the WB-stage bubble control pattern.
package cpu_pipe_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_RAM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    typedef struct packed {
        logic valid;
        logic we;
    } wb_ctl_t;

    // Control bits of an empty WB slot; rd and data are zeroed alongside.
    localparam wb_ctl_t WB_BUBBLE = '{valid: 1'b0, we: 1'b0};

endpackage

// File: rtl/wb_sel_mux.sv
// Write-back source selector: ALU, RAM, link address (pc + PC_INC) or immediate.
// Shared by the forwarding tap and the registered write-back path.
module wb_sel_mux
    import cpu_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PC_INC = 1
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu,
    input  logic [XLEN-1:0] ram,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] link;

    // Wraps modulo 2^XLEN.
    assign link = pc + XLEN'(PC_INC);

    always_comb begin
        data = alu;
        unique case (sel)
            WB_ALU:  data = alu;
            WB_RAM:  data = ram;
            WB_LINK: data = link;
            WB_IMM:  data = imm;
            default: data = alu;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select, forwarding tap,
// halt freeze and a saturating retired-instruction counter.
module mem_wb_stage
    import cpu_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int PC_INC  = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic               in_halt,
    input  logic               in_regwrite,
    input  logic [1:0]         in_wbsel,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_alu,
    input  logic [XLEN-1:0]    in_ram,
    input  logic [XLEN-1:0]    in_imm,
    output logic               wb_valid,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic               halt_o,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]    fwd_data,
    output logic [CNT_W-1:0]   retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] sel_data;
    logic            writes;

    wb_sel_mux #(
        .XLEN   (XLEN),
        .PC_INC (PC_INC)
    ) u_sel (
        .sel  (in_wbsel),
        .pc   (in_pc),
        .alu  (in_alu),
        .ram  (in_ram),
        .imm  (in_imm),
        .data (sel_data)
    );

    // x0 is hardwired zero, so writes to it are dropped here.
    assign writes    = in_valid & in_regwrite & (in_rd != '0);
    assign fwd_valid = writes & ~halt_o;
    assign fwd_rd    = in_rd;
    assign fwd_data  = sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            {wb_valid, wb_we} <= WB_BUBBLE;
            wb_rd      <= '0;
            wb_data    <= '0;
            halt_o     <= 1'b0;
            retire_cnt <= '0;
        end else if (halt_o) begin
            {wb_valid, wb_we} <= WB_BUBBLE;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (stall) begin
            wb_valid <= wb_valid;
        end else if (flush) begin
            {wb_valid, wb_we} <= WB_BUBBLE;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_valid <= in_valid;
            wb_we    <= writes;
            wb_rd    <= in_rd;
            wb_data  <= sel_data;
            halt_o   <= in_valid & in_halt;
            if (in_valid && retire_cnt != CNT_MAX)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a reference model predicts each edge,
// expectations are queued on drive and popped after the edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_valid, in_halt, in_regwrite;
    logic [1:0]  in_wbsel;
    logic [4:0]  in_rd;
    logic [31:0] in_pc, in_alu, in_ram, in_imm;

    logic        wb_valid, wb_we, halt_o, fwd_valid;
    logic [4:0]  wb_rd, fwd_rd;
    logic [31:0] wb_data, fwd_data, retire_cnt;

    logic        s_valid, s_we, s_halt, s_fwd_valid;
    logic [4:0]  s_rd, s_fwd_rd;
    logic [31:0] s_data, s_fwd_data;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_halt(in_halt), .in_regwrite(in_regwrite),
        .in_wbsel(in_wbsel), .in_rd(in_rd), .in_pc(in_pc),
        .in_alu(in_alu), .in_ram(in_ram), .in_imm(in_imm),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .halt_o(halt_o), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retire_cnt(retire_cnt)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_halt(in_halt), .in_regwrite(in_regwrite),
        .in_wbsel(in_wbsel), .in_rd(in_rd), .in_pc(in_pc),
        .in_alu(in_alu), .in_ram(in_ram), .in_imm(in_imm),
        .wb_valid(s_valid), .wb_we(s_we), .wb_rd(s_rd),
        .wb_data(s_data), .halt_o(s_halt), .fwd_valid(s_fwd_valid),
        .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data), .retire_cnt(s_cnt)
    );

    typedef struct {
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        h;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_sel(input logic [1:0] s,
        input logic [31:0] pc, alu, ram, imm);
        if (s == 2'd1) return ram;
        if (s == 2'd2) return pc + 32'd1;
        if (s == 2'd3) return imm;
        return alu;
    endfunction

    task automatic set_in(input logic v, h, rw, input logic [1:0] s,
                          input logic [4:0] rd, input logic [31:0] pc,
                          alu, ram, imm);
        in_valid = v; in_halt = h; in_regwrite = rw; in_wbsel = s;
        in_rd = rd; in_pc = pc; in_alu = alu; in_ram = ram; in_imm = imm;
    endtask

    task automatic rand_in(input logic h);
        set_in(1'b1, h, 1'($urandom), 2'($urandom), 5'($urandom),
               $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic step(input logic st, fl, r);
        exp_t e, n;
        logic [31:0] sd;
        logic        fv;
        stall = st; flush = fl; rst = r;
        #1;
        sd = ref_sel(in_wbsel, in_pc, in_alu, in_ram, in_imm);
        fv = in_valid & in_regwrite & (in_rd != 5'd0) & ~m.h;
        check("fwd_valid", 32'(fwd_valid), 32'(fv));
        check("fwd_rd", 32'(fwd_rd), 32'(in_rd));
        check("fwd_data", fwd_data, sd);
        n = m;
        if (r) begin
            n = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 4'd0};
        end else if (m.h || (!st && fl)) begin
            n.v = 1'b0; n.we = 1'b0; n.rd = 5'd0; n.data = 32'd0;
        end else if (!st) begin
            n.v = in_valid;
            n.we = in_valid & in_regwrite & (in_rd != 5'd0);
            n.rd = in_rd;
            n.data = sd;
            n.h = in_valid & in_halt;
            if (in_valid && m.cnt != 32'hFFFF_FFFF) n.cnt = m.cnt + 32'd1;
            if (in_valid && m.cnt4 != 4'd15) n.cnt4 = m.cnt4 + 4'd1;
        end
        m = n;
        q.push_back(n);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("wb_valid", 32'(wb_valid), 32'(e.v));
        check("wb_we", 32'(wb_we), 32'(e.we));
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_data", wb_data, e.data);
        check("halt_o", 32'(halt_o), 32'(e.h));
        check("retire_cnt", retire_cnt, e.cnt);
        check("retire_cnt4", 32'(s_cnt), 32'(e.cnt4));
    endtask

    initial begin
        m = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 4'd0};
        set_in(0, 0, 0, 2'd0, 5'd0, 0, 0, 0, 0);
        stall = 0; flush = 0; rst = 1;
        @(negedge clk);
        step(0, 0, 1);
        step(0, 0, 1);
        // basic captures over every source
        set_in(1, 0, 1, 2'd0, 5'd3, 32'h40, 32'h1234, 32'h9, 32'h7);
        step(0, 0, 0);
        set_in(1, 0, 1, 2'd2, 5'd4, 32'h10, 32'h1, 32'h2, 32'h3);
        step(0, 0, 0);
        set_in(1, 0, 1, 2'd2, 5'd6, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3);
        step(0, 0, 0);
        set_in(1, 0, 1, 2'd1, 5'd7, 32'h0, 32'h1, 32'h55AA, 32'h3);
        step(0, 0, 0);
        set_in(1, 0, 1, 2'd3, 5'd31, 32'h0, 32'h1, 32'h2, 32'hBEEF);
        step(0, 0, 0);
        // x0 destination: valid retire, no write
        set_in(1, 0, 1, 2'd0, 5'd0, 32'h0, 32'hDEAD, 32'h2, 32'h3);
        step(0, 0, 0);
        set_in(1, 0, 1, 2'd0, 5'd9, 32'h0, 32'hCAFE, 32'h2, 32'h3);
        step(0, 0, 0);
        // stall holds, stall+flush holds, flush alone bubbles
        for (int i = 0; i < 3; i++) begin
            rand_in(1'b0);
            step(1, 0, 0);
        end
        rand_in(1'b0);
        step(1, 1, 0);
        rand_in(1'b1);
        step(0, 1, 0);
        set_in(0, 0, 1, 2'd0, 5'd2, 0, 32'h77, 0, 0);
        step(0, 0, 0);
        // stalled/flushed halt must not freeze
        set_in(1, 1, 1, 2'd0, 5'd2, 0, 32'h77, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        // saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            rand_in(1'b0);
            step(0, 0, 0);
        end
        // halt retires with its write, then freeze
        set_in(1, 1, 1, 2'd3, 5'd5, 32'h0, 32'h1, 32'h2, 32'hABCD_0000);
        step(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            rand_in(1'($urandom));
            step(1'(i == 1), 1'(i == 2), 0);
        end
        rand_in(1'b0);
        step(0, 0, 1);
        set_in(1, 0, 1, 2'd0, 5'd8, 32'h0, 32'h4321, 32'h2, 32'h3);
        step(0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline stage for the optimised streamline CPU. It registers the memory-stage result bundle and performs write-back source selection. It supplies a combinational forwarding tap to the redirection unit. It adds stall/flush control, a valid bit, register-0 write suppression, halt freeze with post-halt squash, and a saturating retired-instruction counter.

## Interface
- XLEN, 32, datapath width
- RADDR_W, 5, register-address width
- PC_INC, 1, added to PC for link value (word-addressed PC)
- CNT_W, 32, retire-counter width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold all stage registers
- flush  in  1  capture a bubble instead of inputs
- in_valid  in  1  MEM-stage bundle is a real instruction
- in_halt  in  1  instruction is halt (syscall-halt)
- in_regwrite  in  1  instruction writes a register
- in_wbsel  in  2  write-back source: 0 ALU, 1 RAM, 2 PC+PC_INC, 3 IMM (lui)
- in_rd  in  RADDR_W  destination register
- in_pc, in_alu, in_ram, in_imm  in  XLEN each  source operands
- wb_valid  out  1  registered valid
- wb_we  out  1  register-file write enable
- wb_rd  out  RADDR_W  register-file write address
- wb_data  out  XLEN  registered write-back data
- halt_o  out  1  sticky halt, held until rst
- fwd_valid  out  1  forwarding tap carries a usable result
- fwd_rd  out  RADDR_W  forwarding destination (= in_rd)
- fwd_data  out  XLEN  combinational selected data from inputs
- retire_cnt  out  CNT_W  instructions retired into WB

## Operation
- Selection: data = wbsel 0 → alu, 1 → ram, 2 → pc + PC_INC (mod 2^XLEN), 3 → imm. The same function is applied to the inputs (fwd_data) and ahead of the wb_data register.
- Per-clock priority: rst > halt_o=1 > stall > flush > capture.
- rst: wb_valid, wb_we, wb_rd, wb_data, halt_o, retire_cnt all 0.
- halt_o=1 (frozen): stage captures a bubble every cycle. Bubble = wb_valid 0, wb_we 0, wb_rd 0, wb_data 0. stall, flush and in_halt are ignored. retire_cnt is frozen.
- stall: all registers keep their values; retire_cnt unchanged.
- flush: capture bubble; retire_cnt unchanged.
- capture:
  - wb_valid ← in_valid
  - wb_we ← in_valid & in_regwrite & (in_rd ≠ 0)
  - wb_rd ← in_rd; wb_data ← selected data
  - halt_o ← in_valid & in_halt
  - retire_cnt += in_valid, saturating at 2^CNT_W−1
- The halt instruction itself retires normally, including its write if regwrite=1. Every later instruction is squashed.
- fwd_valid = in_valid & in_regwrite & (in_rd ≠ 0) & ~halt_o. It is independent of stall and flush.

## Timing
- Capture-to-output latency: 1 clk.
- halt_o rises the cycle after the halt bundle is captured. If that capture is stalled or flushed, halt_o stays 0.
- fwd_* is purely combinational. It has no registered path and zero latency.
- stall and flush asserted together: stall wins and registers hold. Releasing stall alone with flush still high captures a bubble.
- rst asserted in any state: all outputs are 0 on the next edge, including a set halt_o.

## Structure
- Package cpu_pipe_pkg holds:
  - wbsel encodings WB_ALU=0, WB_RAM=1, WB_LINK=2, WB_IMM=3
  - the bubble constant
- Sub-module wb_sel_mux: combinational 4:1 source select plus PC+PC_INC adder. It is instantiated once and feeds both fwd_data and the wb_data register.

## Test plan
- Reset, then capture in_valid=1, wbsel=0, alu=0x1234, rd=3, regwrite=1 → next cycle wb_we=1, wb_rd=3, wb_data=0x1234, retire_cnt=1.
- wbsel=2, pc=0x10 → wb_data=0x11 and fwd_data=0x11 in the same cycle as the input. pc=0xFFFFFFFF → 0x0.
- regwrite=1 with rd=0 → wb_we=0, fwd_valid=0, wb_valid=1, retire_cnt increments.
- Stall for 3 cycles while inputs change → outputs and retire_cnt hold. Then stall+flush together → hold. Then flush alone → bubble, retire_cnt unchanged.
- Halt bundle with regwrite=1, rd=5, imm=0xABCD0000, wbsel=3:
  - next cycle halt_o=1, wb_we=1, wb_data=0xABCD0000
  - following cycles: bubbles, fwd_valid=0, counter frozen, despite valid inputs
  - rst clears halt_o
- CNT_W=4: retire 20 valid instructions → retire_cnt saturates at 15.
